// File: rtl/uart_tx_sched_if.sv
// -----------------------------------------------------------------------------
// uart_tx_sched_if
// Purpose : bundles the host write handshake, the transmit-buffer port and the
//           serial/status outputs of uart_tx_sched into one interface.
// Signals :
//   host_wr, host_data     - host request to queue a byte
//   host_full, count       - write refused this cycle / occupied slot count
//   buf_paddr, buf_wr,
//   buf_rd, buf_wdata      - single address/strobe port into the 4-entry buffer
//   buf_rdata              - registered buffer read data
//   txd, tx_busy, tx_empty - serial line and transmitter status
// Modports: slave  - the scheduler (uart_tx_sched)
//           master - host + buffer side (drives host_wr/host_data/buf_rdata)
// -----------------------------------------------------------------------------
interface uart_tx_sched_if #(
    parameter int unsigned BITWIDTH = 8
);
    logic                host_wr;
    logic [BITWIDTH-1:0] host_data;
    logic                host_full;
    logic [2:0]          count;
    logic [1:0]          buf_paddr;
    logic                buf_wr;
    logic                buf_rd;
    logic [BITWIDTH-1:0] buf_wdata;
    logic [BITWIDTH-1:0] buf_rdata;
    logic                txd;
    logic                tx_busy;
    logic                tx_empty;

    modport slave (
        input  host_wr, host_data, buf_rdata,
        output host_full, count, buf_paddr, buf_wr, buf_rd, buf_wdata,
               txd, tx_busy, tx_empty
    );

    modport master (
        output host_wr, host_data, buf_rdata,
        input  host_full, count, buf_paddr, buf_wr, buf_rd, buf_wdata,
               txd, tx_busy, tx_empty
    );
endinterface

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Purpose : transmit scheduler for the 4-entry CoreUART TX buffer. Treats the
//           buffer as a circular queue, arbitrates its single port between
//           host writes (priority) and its own fetches, and serialises each
//           fetched byte onto txd as 8N1 (or 8E1) at BAUD_DIV clocks per bit.
// Ports   :
//   tClk - clock, rising edge
//   tRst - synchronous active-high reset; aborts any frame, empties the queue
//   bus  - uart_tx_sched_if.slave (host handshake, buffer port, txd, status)
// Parameters:
//   BAUD_DIV - clocks per serial bit (2..65535)
//   BITWIDTH - data width, matches the buffer (8)
// Build option:
//   UART_TX_PARITY_EN - when defined, adds an even-parity bit (PAR state).
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int unsigned BAUD_DIV = 16,
    parameter int unsigned BITWIDTH = 8
) (
    input  logic           tClk,
    input  logic           tRst,
    uart_tx_sched_if.slave bus
);
    localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd6
`ifdef UART_TX_PARITY_EN
        ,S_PAR  = 3'd5
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          wp_q, wp_d;
    logic [1:0]          rp_q, rp_d;
    logic [2:0]          count_q, count_d;
    logic [15:0]         timer_q, timer_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [BITWIDTH-1:0] shreg_q, shreg_d;
    logic                txd_q, txd_d;

    logic                host_full_s;
    logic                wr_accept_s;
    logic                load_s;
    logic                bit_end_s;
    logic                tx_busy_s;

`ifdef UART_TX_PARITY_EN
    // Even parity: the XOR of the data bits makes the total count of ones even.
    function automatic logic even_parity(input logic [BITWIDTH-1:0] data);
        even_parity = ^data;
    endfunction
`endif

    // Port arbitration: a write owns the buffer port unless the queue is full
    // or a fetch already holds the port this cycle.
    always_comb begin
        host_full_s = (count_q == 3'd4) || (state_q == S_FETCH);
        wr_accept_s = bus.host_wr && !host_full_s;
        load_s      = (state_q == S_LOAD);
        bit_end_s   = (timer_q == 16'd0);
    end

    // Frame sequencer: next state, bit timer, bit index and shift register.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        case (state_q)
            S_IDLE: begin
                // A fetch waits while the host is writing so the port is never shared.
                if ((count_q != 3'd0) && !bus.host_wr) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = bus.buf_rdata;
                timer_d = BIT_LAST;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    timer_d   = BIT_LAST;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    timer_d = BIT_LAST;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PAR: begin
                if (bit_end_s) begin
                    state_d = S_STOP;
                    timer_d = BIT_LAST;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Queue bookkeeping: a write and a load in the same cycle cancel in count.
    always_comb begin
        wp_d    = wr_accept_s ? (wp_q + 2'd1) : wp_q;
        rp_d    = load_s ? (rp_q + 2'd1) : rp_q;
        count_d = count_q + {2'b00, wr_accept_s} - {2'b00, load_s};
    end

    // Line level for the upcoming state; registering it keeps txd aligned with state_q.
    always_comb begin
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shreg_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            S_PAR:   txd_d = even_parity(shreg_d);
`endif
            default: txd_d = 1'b1;
        endcase
    end

    // Busy covers every state that drives a frame bit onto the line.
    always_comb begin
        case (state_q)
            S_START: tx_busy_s = 1'b1;
            S_DATA:  tx_busy_s = 1'b1;
`ifdef UART_TX_PARITY_EN
            S_PAR:   tx_busy_s = 1'b1;
`endif
            S_STOP:  tx_busy_s = 1'b1;
            default: tx_busy_s = 1'b0;
        endcase
    end

    // State register; reset drops the frame in flight and discards queued data.
    always_ff @(posedge tClk) begin
        if (tRst) begin
            state_q   <= S_IDLE;
            wp_q      <= 2'd0;
            rp_q      <= 2'd0;
            count_q   <= 3'd0;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shreg_q   <= {BITWIDTH{1'b0}};
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            txd_q     <= txd_d;
        end
    end

    assign bus.host_full = host_full_s;
    assign bus.count     = count_q;
    assign bus.buf_wr    = wr_accept_s;
    assign bus.buf_rd    = (state_q == S_FETCH);
    assign bus.buf_paddr = wr_accept_s ? wp_q : rp_q;
    assign bus.buf_wdata = bus.host_data;
    assign bus.txd       = txd_q;
    assign bus.tx_busy   = tx_busy_s;
    assign bus.tx_empty  = (count_q == 3'd0) && (state_q == S_IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched with BAUD_DIV=4. Models the 4-entry
// registered buffer, keeps a scoreboard of accepted bytes, and decodes txd
// frames bit by bit against the expected frame built from the scoreboard.
// Honours UART_TX_PARITY_EN for frame length and parity bit.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;
    localparam int B       = 4;
    localparam int RX_WAIT = 200;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] sb[$];
    logic [1:0] exp_wp;
    logic [7:0] mem [4];

    uart_tx_sched_if #(.BITWIDTH(8)) bus_if ();

    uart_tx_sched #(.BAUD_DIV(B), .BITWIDTH(8)) dut (
        .tClk (clk),
        .tRst (rst),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmit buffer model: synchronous write, registered read.
    always @(posedge clk) begin
        if (bus_if.buf_wr === 1'b1) mem[bus_if.buf_paddr] <= bus_if.buf_wdata;
        if (bus_if.buf_rd === 1'b1) bus_if.buf_rdata <= mem[bus_if.buf_paddr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NB-1:0] mk_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        mk_frame = {1'b1, ^d, d, 1'b0};
`else
        mk_frame = {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic write_byte(input logic [7:0] d, input logic acc);
        @(posedge clk); #1;
        bus_if.host_wr   = 1'b1;
        bus_if.host_data = d;
        @(negedge clk);
        checks++;
        if (bus_if.buf_wr !== acc || bus_if.host_full !== !acc ||
            (acc && bus_if.buf_paddr !== exp_wp)) begin
            failures++;
            $display("FAIL wr_accept data=%h: buf_wr=%b host_full=%b paddr=%0d, want buf_wr=%b paddr=%0d",
                     d, bus_if.buf_wr, bus_if.host_full, bus_if.buf_paddr, acc, exp_wp);
        end
        checks++;
        if (bus_if.buf_wr === 1'b1 && bus_if.buf_rd === 1'b1) begin
            failures++;
            $display("FAIL port_excl: buf_wr=1 buf_rd=1, want never both");
        end
        if (acc) begin
            sb.push_back(d);
            exp_wp = exp_wp + 2'd1;
        end
    endtask

    task automatic release_wr();
        @(posedge clk); #1;
        bus_if.host_wr = 1'b0;
    endtask

    // Waits for a start bit, then collects NB bits, checking each holds B cycles.
    task automatic rx_frame(output int gap, output logic [NB-1:0] bits,
                            output logic stable, output int busy_cnt);
        logic bitv;
        gap = 0; bits = '1; stable = 1'b1; busy_cnt = 0;
        @(negedge clk);
        while (bus_if.txd !== 1'b0 && gap < RX_WAIT) begin
            gap++;
            @(negedge clk);
        end
        if (bus_if.txd !== 1'b0) begin
            stable = 1'b0;
            return;
        end
        for (int b = 0; b < NB; b++) begin
            bitv = bus_if.txd;
            for (int s = 0; s < B; s++) begin
                if (s != 0) @(negedge clk);
                if (bus_if.txd !== bitv) stable = 1'b0;
                if (bus_if.tx_busy === 1'b1) busy_cnt++;
            end
            bits[b] = bitv;
            if (b != NB - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.host_wr = 1'b1;
        bus_if.host_data = 8'hEE;
        repeat (3) @(posedge clk);
        #1 bus_if.host_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.txd !== 1'b1 || bus_if.count !== 3'd0 || bus_if.tx_busy !== 1'b0 ||
            bus_if.tx_empty !== 1'b1 || bus_if.host_full !== 1'b0 ||
            bus_if.buf_rd !== 1'b0 || bus_if.buf_wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: txd=%b count=%0d busy=%b empty=%b full=%b rd=%b wr=%b, want 1 0 0 1 0 0 0",
                     bus_if.txd, bus_if.count, bus_if.tx_busy, bus_if.tx_empty,
                     bus_if.host_full, bus_if.buf_rd, bus_if.buf_wr);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.count !== 3'd0 || bus_if.txd !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: count=%0d txd=%b, want 0 1", bus_if.count, bus_if.txd);
        end
        exp_wp = 2'd0;
    endtask

    task automatic test_single();
        int gap, busy;
        logic [NB-1:0] bits;
        logic stable;
        logic [7:0] e;
        write_byte(8'hA5, 1'b1);
        release_wr();
        @(negedge clk);
        checks++;
        if (bus_if.count !== 3'd1 || bus_if.tx_empty !== 1'b0 || bus_if.buf_rd !== 1'b0) begin
            failures++;
            $display("FAIL single_c1: count=%0d empty=%b rd=%b, want 1 0 0",
                     bus_if.count, bus_if.tx_empty, bus_if.buf_rd);
        end
        @(negedge clk);
        checks++;
        if (bus_if.buf_rd !== 1'b1 || bus_if.buf_paddr !== 2'd0 || bus_if.host_full !== 1'b1) begin
            failures++;
            $display("FAIL single_fetch: rd=%b paddr=%0d full=%b, want 1 0 1",
                     bus_if.buf_rd, bus_if.buf_paddr, bus_if.host_full);
        end
        @(negedge clk);
        checks++;
        if (bus_if.txd !== 1'b1 || bus_if.tx_busy !== 1'b0 || bus_if.buf_rd !== 1'b0) begin
            failures++;
            $display("FAIL single_load: txd=%b busy=%b rd=%b, want 1 0 0",
                     bus_if.txd, bus_if.tx_busy, bus_if.buf_rd);
        end
        rx_frame(gap, bits, stable, busy);
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        checks++;
        if (gap !== 0 || stable !== 1'b1 || bits !== mk_frame(e) || busy !== NB * B) begin
            failures++;
            $display("FAIL single_frame: gap=%0d stable=%b bits=%b busy=%0d, want 0 1 %b %0d",
                     gap, stable, bits, busy, mk_frame(e), NB * B);
        end
        @(negedge clk);
        checks++;
        if (bus_if.tx_empty !== 1'b1 || bus_if.txd !== 1'b1) begin
            failures++;
            $display("FAIL single_empty: empty=%b txd=%b, want 1 1", bus_if.tx_empty, bus_if.txd);
        end
    endtask

    task automatic test_full();
        int gap, busy;
        logic [NB-1:0] bits;
        logic stable;
        logic [7:0] e;
        for (int i = 1; i <= 4; i++) write_byte(8'(i), 1'b1);
        write_byte(8'hFF, 1'b0);
        checks++;
        if (bus_if.count !== 3'd4) begin
            failures++;
            $display("FAIL full_count: count=%0d, want 4", bus_if.count);
        end
        release_wr();
        for (int i = 0; i < 4; i++) begin
            rx_frame(gap, bits, stable, busy);
            e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
            checks++;
            if (gap !== 3 || stable !== 1'b1 || bits !== mk_frame(e)) begin
                failures++;
                $display("FAIL full_frame%0d: gap=%0d stable=%b bits=%b, want 3 1 %b",
                         i, gap, stable, bits, mk_frame(e));
            end
        end
    endtask

    task automatic test_defer();
        int gap, busy;
        logic [NB-1:0] bits;
        logic stable;
        logic [7:0] e;
        for (int i = 0; i < 6; i++) write_byte(8'h10 + 8'(i), (i < 4) ? 1'b1 : 1'b0);
        release_wr();
        @(negedge clk);
        checks++;
        if (bus_if.buf_rd !== 1'b0) begin
            failures++;
            $display("FAIL defer_idle: buf_rd=%b, want 0", bus_if.buf_rd);
        end
        @(negedge clk);
        checks++;
        if (bus_if.buf_rd !== 1'b1 || bus_if.buf_wr !== 1'b0) begin
            failures++;
            $display("FAIL defer_fetch: buf_rd=%b buf_wr=%b, want 1 0", bus_if.buf_rd, bus_if.buf_wr);
        end
        for (int i = 0; i < 4; i++) begin
            rx_frame(gap, bits, stable, busy);
            e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
            checks++;
            if (gap !== ((i == 0) ? 1 : 3) || stable !== 1'b1 || bits !== mk_frame(e)) begin
                failures++;
                $display("FAIL defer_frame%0d: gap=%0d stable=%b bits=%b, want %0d 1 %b",
                         i, gap, stable, bits, (i == 0) ? 1 : 3, mk_frame(e));
            end
        end
    endtask

    task automatic test_wrap();
        int gap, busy;
        logic [NB-1:0] bits;
        logic stable;
        logic [7:0] e;
        write_byte(8'h61, 1'b1);
        write_byte(8'h62, 1'b1);
        release_wr();
        fork
            begin
                repeat (15) @(posedge clk);
                write_byte(8'h63, 1'b1);
                write_byte(8'h64, 1'b1);
                write_byte(8'h65, 1'b1);
                release_wr();
                repeat (40) @(posedge clk);
                write_byte(8'h66, 1'b1);
                release_wr();
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    rx_frame(gap, bits, stable, busy);
                    e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                    checks++;
                    if (gap !== 3 || stable !== 1'b1 || bits !== mk_frame(e)) begin
                        failures++;
                        $display("FAIL wrap_frame%0d: gap=%0d stable=%b bits=%b, want 3 1 %b",
                                 i, gap, stable, bits, mk_frame(e));
                    end
                end
            end
        join
    endtask

    task automatic test_reset_mid();
        logic quiet;
        write_byte(8'h35, 1'b1);
        write_byte(8'hC3, 1'b1);
        release_wr();
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_if.txd !== 1'b0 || bus_if.tx_busy !== 1'b1 || bus_if.count !== 3'd1) begin
            failures++;
            $display("FAIL mid_bit3: txd=%b busy=%b count=%0d, want 0 1 1",
                     bus_if.txd, bus_if.tx_busy, bus_if.count);
        end
        @(negedge clk);
        checks++;
        if (bus_if.txd !== 1'b1 || bus_if.count !== 3'd0 || bus_if.tx_busy !== 1'b0 ||
            bus_if.tx_empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: txd=%b count=%0d busy=%b empty=%b, want 1 0 0 1",
                     bus_if.txd, bus_if.count, bus_if.tx_busy, bus_if.tx_empty);
        end
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        exp_wp = 2'd0;
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (bus_if.txd !== 1'b1 || bus_if.buf_rd !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL mid_quiet: line activity after reset, want txd=1 buf_rd=0 throughout");
        end
    endtask

    task automatic test_frame_len();
        int gap, busy;
        logic [NB-1:0] bits;
        logic stable;
        logic [7:0] e;
        write_byte(8'h07, 1'b1);
        release_wr();
        rx_frame(gap, bits, stable, busy);
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        checks++;
        if (gap !== 3 || stable !== 1'b1 || bits !== mk_frame(e) || busy !== NB * B) begin
            failures++;
            $display("FAIL len_frame: gap=%0d stable=%b bits=%b busy=%0d, want 3 1 %b %0d",
                     gap, stable, bits, busy, mk_frame(e), NB * B);
        end
        @(negedge clk);
        checks++;
        if (bus_if.tx_busy !== 1'b0 || bus_if.txd !== 1'b1) begin
            failures++;
            $display("FAIL len_end: busy=%b txd=%b, want 0 1", bus_if.tx_busy, bus_if.txd);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_wp = 2'd0;
        bus_if.host_wr = 1'b0;
        bus_if.host_data = 8'h00;
        rst = 1'b1;
        test_reset();
        test_single();
        test_full();
        test_defer();
        test_wrap();
        test_reset_mid();
        test_frame_len();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d bytes never transmitted, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side controller for the CoreUART 4-entry transmit buffer. It owns the buffer's single address/strobe port and arbitrates between host writes and its own fetches, treating the four slots as a circular queue. It fetches queued bytes in order and serialises each one onto `txd` as an 8N1 frame (optionally 8E1) at a programmable bit period. It sits between the host register interface and the TX pin, with the buffer as its only storage.

## Interface
Parameters:
- `BAUD_DIV`, default 16: clocks per serial bit. Legal range is 2..65535.
- `BITWIDTH`, default 8: data width. It matches the buffer.

Ports:
- `tClk`, input, 1: the single clock. All logic uses the rising edge.
- `tRst`, input, 1: reset. Synchronous, active-high.
- `host_wr`, input, 1: host asks to queue `host_data` this cycle.
- `host_data`, input, BITWIDTH: byte to queue.
- `host_full`, output, 1: write refused this cycle. Defined as `(count==4) || (state==FETCH)`.
- `count`, output, 3: number of occupied slots, 0..4.
- `buf_paddr`, output, 2: buffer slot address. Equals `wp` when `buf_wr` is high, `rp` otherwise.
- `buf_wr`, output, 1: buffer write strobe. Equals `host_wr && !host_full` (combinational).
- `buf_rd`, output, 1: buffer read strobe. High only in FETCH.
- `buf_wdata`, output, BITWIDTH: equals `host_data`.
- `buf_rdata`, input, BITWIDTH: registered buffer output. Valid only in the cycle after `buf_rd`.
- `txd`, output, 1: serial line. Registered. Idles high.
- `tx_busy`, output, 1: high in states START, DATA, PAR, STOP.
- `tx_empty`, output, 1: high when `count==0` and state is IDLE.

## Operation
- Queue bookkeeping:
  - `wp` and `rp` are 2-bit pointers that wrap 3→0.
  - An accepted write stores at `wp`, then increments `wp` and `count`.
  - LOAD increments `rp` and decrements `count`.
  - An accepted write in the same cycle as LOAD leaves `count` unchanged.
  - A write while `host_full` is high is dropped silently. `wp` and `count` are untouched.
- Port exclusivity: `buf_wr` and `buf_rd` are never high in the same cycle. Host writes take priority; a fetch is deferred while a write is in progress.
- State machine:
  - IDLE: if `count>0` and `host_wr` is low, go to FETCH. Otherwise stay in IDLE.
  - FETCH (1 cycle): `buf_rd=1`, `buf_paddr=rp`. Go to LOAD.
  - LOAD (1 cycle): `shreg <= buf_rdata`, update `rp` and `count`. Go to START.
  - START: `txd=0` for BAUD_DIV clocks. Go to DATA.
  - DATA: send bits LSB first, each for BAUD_DIV clocks. A 3-bit index counts 0..7. After bit 7, go to PAR if enabled, else STOP.
  - PAR: `txd` is the XOR of the byte, for BAUD_DIV clocks. Go to STOP.
  - STOP: `txd=1` for BAUD_DIV clocks. Go to IDLE.
- Bit timer:
  - 16-bit down-counter, loaded with BAUD_DIV-1 on entry to each bit.
  - The bit ends in the cycle the counter reads 0.
- Reset:
  - State IDLE, `txd=1`, `wp=rp=0`, `count=0`.
  - `tx_busy=0`, `tx_empty=1`, `host_full=0`.
  - `buf_rd=0`; `buf_wr=0` while `host_wr` is low.
  - Reset mid-frame aborts the frame: `txd` is high from the next edge and all queued data is discarded.
  - `host_wr` is ignored while `tRst` is high.

## Timing
- A write in cycle 0 to an empty, idle queue gives:
  - FETCH in cycle 2.
  - LOAD in cycle 3.
  - `txd` low in cycles 4..3+BAUD_DIV.
- Frame length is 10·BAUD_DIV clocks, or 11·BAUD_DIV with parity.
- Back-to-back frames have 3 extra idle-high cycles between the end of STOP and the next start bit (IDLE, FETCH, LOAD). The gap grows by 1 per cycle that `host_wr` is held high in IDLE.
- A slot becomes writable again in the cycle after LOAD.
- With a full queue, `host_full` drops in the cycle after LOAD.

## Configuration
- `UART_TX_PARITY_EN` defined: the PAR state is compiled in and frames are 8E1 (even parity).
- Undefined: no PAR state, frames are 8N1, and `txd` goes straight from DATA bit 7 to STOP.

## Test plan
- Reset, then write 0xA5 with BAUD_DIV=4 → `txd` low in cycles 4..7, then bits 1,0,1,0,0,1,0,1, then high. `tx_empty` returns to 1 after STOP.
- Write 0x01,0x02,0x03,0x04 on consecutive cycles, then a 5th write 0xFF → `count=4`, `host_full=1`, and 0xFF is dropped. Frames come out 01,02,03,04 with a 3-cycle gap between frames.
- Hold `host_wr` high in IDLE with `count=1` → FETCH deferred, and `buf_rd` and `buf_wr` are never high together. FETCH occurs in the first cycle after `host_wr` falls.
- Write 6 bytes across two frames → pointers wrap 3→0 and output order matches input order.
- Assert `tRst` during DATA bit 3 → `txd=1`, `count=0`, state IDLE on the next edge. No further frames are sent.
- With `UART_TX_PARITY_EN` defined, send 0x07 → parity bit is 1 and the frame is 11·BAUD_DIV clocks long.
